// File: rtl/instr_assembler.sv
// Instruction assembler: collects an opcode and its operand bytes from the fetch stream
// and presents the finished word through a single-entry valid/ready output register.
module instr_assembler #(
    parameter bit EMIT_NOP = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             out_ready,
    output logic             instr_valid,
    output logic [7:0]       instr_op,
    output logic [7:0]       instr_r1,
    output logic [7:0]       instr_r2,
    output logic [15:0]      instr_data,
    output logic [2:0]       instr_len,
    output logic             instr_illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {S_OP, S_B1, S_B2, S_B3} state_e;

    function automatic logic [2:0] op_len(input logic [7:0] op);
        case (op)
            8'h01, 8'h02:        op_len = 3'd3;
            8'h03, 8'h04, 8'h05: op_len = 3'd4;
            default:             op_len = 3'd1;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  r1_q, r1_d;
    logic [7:0]  r2_q, r2_d;
    logic [15:0] data_q, data_d;
    logic        complete;
    logic        accept;
    logic        load;

    logic             valid_q;
    logic [7:0]       out_op_q, out_r1_q, out_r2_q;
    logic [15:0]      out_data_q;
    logic [2:0]       out_len_q;
    logic             out_ill_q;
    logic [CNT_W-1:0] cnt_q;

    assign byte_ready = !flush && (!valid_q || out_ready);
    assign accept     = byte_valid && byte_ready;
    assign load       = accept && complete;

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        data_d   = data_q;
        complete = 1'b0;
        case (state_q)
            S_OP: begin
                op_d   = byte_in;
                r1_d   = 8'h00;
                r2_d   = 8'h00;
                data_d = 16'h0000;
                if (op_len(byte_in) == 3'd1) complete = (byte_in != 8'h00) || EMIT_NOP;
                else                         state_d  = S_B1;
            end
            S_B1: begin
                state_d = S_B2;
                if (op_q == 8'h05) data_d[7:0] = byte_in;
                else               r1_d        = byte_in;
            end
            S_B2: begin
                case (op_q)
                    8'h01:   begin data_d = {8'h00, byte_in}; complete = 1'b1; end
                    8'h02:   begin r2_d = byte_in;            complete = 1'b1; end
                    8'h05:   begin data_d[15:8] = byte_in;    state_d = S_B3;  end
                    default: begin data_d[7:0]  = byte_in;    state_d = S_B3;  end
                endcase
            end
            S_B3: begin
                complete = 1'b1;
                if (op_q == 8'h05) r1_d         = byte_in;
                else               data_d[15:8] = byte_in;
            end
            default: state_d = S_OP;
        endcase
        if (complete) state_d = S_OP;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_OP;
            op_q       <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            out_op_q   <= '0;
            out_r1_q   <= '0;
            out_r2_q   <= '0;
            out_data_q <= '0;
            out_len_q  <= '0;
            out_ill_q  <= 1'b0;
            cnt_q      <= '0;
        end else if (flush) begin
            state_q <= S_OP;
            op_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                state_q <= state_d;
                op_q    <= op_d;
                r1_q    <= r1_d;
                r2_q    <= r2_d;
                data_q  <= data_d;
            end
            // A completion on the same edge as a handoff overwrites the slot and keeps valid high.
            if (load) begin
                valid_q    <= 1'b1;
                out_op_q   <= op_d;
                out_r1_q   <= r1_d;
                out_r2_q   <= r2_d;
                out_data_q <= data_d;
                out_len_q  <= op_len(op_d);
                out_ill_q  <= op_d > 8'h05;
                cnt_q      <= cnt_q + 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign instr_valid   = valid_q;
    assign instr_op      = out_op_q;
    assign instr_r1      = out_r1_q;
    assign instr_r2      = out_r2_q;
    assign instr_data    = out_data_q;
    assign instr_len     = out_len_q;
    assign instr_illegal = out_ill_q;
    assign instr_count   = cnt_q;

endmodule
